// File: rtl/restoring_divider.sv
// Unsigned N-bit restoring divider with start/done handshake, one quotient bit per cycle.
// Optional build macro DIVIDER_ZERO_BYPASS_EN: a zero divisor skips RUN and completes one cycle after start.
module restoring_divider #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q;
  logic [N:0]    a_q;
  logic [N-1:0]  q_q, m_q;
  logic [CW-1:0] cnt_q;
  logic          zero_q;
  logic          busy_q, done_q, dbz_q;
  logic [N-1:0]  quot_q, rem_q;

  // One restoring iteration: shift {a,q}, trial-subtract m, keep or restore.
  logic [N:0]   a_sh, t;
  logic [N:0]   a_d;
  logic [N-1:0] q_d;

  always_comb begin
    a_sh = {a_q[N-1:0], q_q[N-1]};
    t    = a_sh - {1'b0, m_q};
    a_d  = t[N] ? a_sh : t;
    q_d  = {q_q[N-2:0], ~t[N]};
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q    <= '0;
            q_q    <= dividend;
            m_q    <= divisor;
            cnt_q  <= CNT_INIT;
            zero_q <= (divisor == '0);
            busy_q <= 1'b1;
`ifdef DIVIDER_ZERO_BYPASS_EN
            if (divisor == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
`else
            state_q <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          // Results are captured from the final iteration so they appear together with done.
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= a_d[N-1:0];
            dbz_q   <= zero_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Randomized and exhaustive self-checking bench for restoring_divider (N=4) against an arithmetic model.
module tb_restoring_divider;
  localparam int N = 4;

  logic         clock = 1'b0;
  logic         n_reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  int n_chk = 0, n_pass = 0;
  int prev_q = 0, prev_r = 0;

  restoring_divider #(.N(N)) dut (
    .clock(clock), .n_reset(n_reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Caller sits at a negedge; returns at the negedge of the IDLE cycle after done.
  task automatic do_div(input int dd, input int dvs, input bit noise);
    int cyc, exp_q, exp_r, exp_z, exp_lat;
    exp_z   = (dvs == 0) ? 1 : 0;
    exp_q   = exp_z ? (1 << N) - 1 : dd / dvs;
    exp_r   = exp_z ? dd : dd % dvs;
`ifdef DIVIDER_ZERO_BYPASS_EN
    exp_lat = exp_z ? 1 : N + 1;
`else
    exp_lat = N + 1;
`endif
    start = 1'b1; dividend = N'(dd); divisor = N'(dvs);
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      chk("busy_run", busy, 1);
      chk("hold_q", quotient, prev_q);
      chk("hold_r", remainder, prev_r);
      if (noise) begin
        start = 1'($urandom); dividend = N'($urandom); divisor = N'($urandom);
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, exp_lat);
    chk("done", done, 1);
    chk("busy_done", busy, 1);
    chk("quotient", quotient, exp_q);
    chk("remainder", remainder, exp_r);
    chk("div_by_zero", div_by_zero, exp_z);
    prev_q = exp_q; prev_r = exp_r;
    @(negedge clock);
    chk("done_once", done, 0);
    chk("busy_idle", busy, 0);
    chk("idle_hold_q", quotient, exp_q);
  endtask

  initial begin
    int seen;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clock); n_reset = 1'b1;
    @(negedge clock);

    do_div(13, 3, 0);
    do_div(15, 1, 0);
    do_div(5, 7, 0);
    do_div(9, 0, 0);
    do_div(14, 4, 1);

    // Reset during the third RUN cycle aborts with no trailing done.
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    @(negedge clock); n_reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);
    prev_q = 0; prev_r = 0;
    do_div(7, 2, 0);

    for (int dd = 0; dd < (1 << N); dd++)
      for (int dv = 0; dv < (1 << N); dv++)
        do_div(dd, dv, 0);

    for (int i = 0; i < 60; i++) begin
      do_div(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 1'($urandom));
      if ($urandom_range(1, 0) == 1) @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
